// File: rtl/operand_collector_pkg.sv
// rtl/operand_collector_pkg.sv - shared compute-unit slot states and default geometry
package operand_collector_pkg;

    typedef logic [1:0] slot_state_t;

    localparam slot_state_t SLOT_FREE    = 2'd0;
    localparam slot_state_t SLOT_COLLECT = 2'd1;
    localparam slot_state_t SLOT_READY   = 2'd2;

    // iid layout shared with dispatcher and execution units: {wid, tag}
    localparam int DefNumTags  = 8;
    localparam int DefNumWarps = 8;

endpackage

// File: rtl/collector_slot.sv
// rtl/collector_slot.sv - one instruction slot: state, operand bookkeeping and data
module collector_slot
    import operand_collector_pkg::*;
#(
    parameter int IidWidth        = 6,
    parameter int RegIdxWidth     = 6,
    parameter int OperandsPerInst = 2,
    parameter int DataWidth       = 1024,
    parameter int OpIdxWidth      = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      alloc,
    input  logic [IidWidth-1:0]                       alloc_tag,
    input  logic [RegIdxWidth-1:0]                    alloc_dst,
    input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0] alloc_ops,
    input  logic                                      req_fire,
    output logic                                      wants,
    output logic [OpIdxWidth-1:0]                     req_op,
    output logic [RegIdxWidth-1:0]                    req_reg,
    input  logic                                      capture,
    input  logic [OpIdxWidth-1:0]                     capture_op,
    input  logic [DataWidth-1:0]                      capture_data,
    input  logic                                      retire,
    output logic                                      free,
    output logic                                      ready,
    output logic [IidWidth-1:0]                       tag,
    output logic [RegIdxWidth-1:0]                    dst,
    output logic [OperandsPerInst-1:0][DataWidth-1:0] data
);

    slot_state_t                                 state;
    logic [OperandsPerInst-1:0]                  requested;
    logic [OperandsPerInst-1:0]                  valid;
    logic [OperandsPerInst-1:0][RegIdxWidth-1:0] ops;
    logic                                        found;

    assign free  = (state == SLOT_FREE);
    assign ready = (state == SLOT_READY);

    always_comb begin
        req_op = '0;
        found  = 1'b0;
        for (int k = 0; k < OperandsPerInst; k++) begin
            if (!found && !requested[k]) begin
                req_op = OpIdxWidth'(k);
                found  = 1'b1;
            end
        end
    end

    assign wants   = (state == SLOT_COLLECT) && found;
    assign req_reg = ops[req_op];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SLOT_FREE;
            requested <= '0;
            valid     <= '0;
        end else begin
            case (state)
                SLOT_FREE: if (alloc) begin
                    state     <= SLOT_COLLECT;
                    requested <= '0;
                    valid     <= '0;
                end
                SLOT_COLLECT: begin
                    if (req_fire) requested[req_op] <= 1'b1;
                    if (capture) valid[capture_op] <= 1'b1;
                    if (&valid) state <= SLOT_READY;
                end
                SLOT_READY: if (retire) state <= SLOT_FREE;
                default: state <= SLOT_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (alloc && state == SLOT_FREE) begin
            tag <= alloc_tag;
            dst <= alloc_dst;
            ops <= alloc_ops;
        end
        if (capture) data[capture_op] <= capture_data;
    end

endmodule

// File: rtl/rr_arb_tree.sv
// rtl/rr_arb_tree.sv - fair round-robin arbiter returning the winning index
module rr_arb_tree #(
    parameter int NumIn    = 4,
    parameter int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NumIn-1:0]    reqs,
    output logic [NumIn-1:0]    grants,
    output logic                valid,
    input  logic                ready,
    output logic [IdxWidth-1:0] idx
);

    logic [IdxWidth-1:0] ptr;
    logic                found;
    int                  j;

    assign valid = |reqs;

    always_comb begin
        idx   = ptr;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NumIn; k++) begin
            j = int'(ptr) + k;
            if (j >= NumIn) j = j - NumIn;
            if (!found && reqs[j]) begin
                idx   = IdxWidth'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grants = '0;
        for (int k = 0; k < NumIn; k++)
            grants[k] = valid && ready && (idx == IdxWidth'(k));
    end

    // While stalled the pointer parks on the current winner so the offer stays put
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (valid)
            ptr <= !ready ? idx :
                   (int'(idx) == NumIn - 1) ? '0 : idx + IdxWidth'(1);
    end

endmodule

// File: rtl/operand_collector.sv
// rtl/operand_collector.sv - buffers dispatched instructions and gathers their register operands
module operand_collector
    import operand_collector_pkg::*;
#(
    parameter int NumTags         = DefNumTags,
    parameter int NumWarps        = DefNumWarps,
    parameter int WarpWidth       = 32,
    parameter int RegWidth        = 32,
    parameter int RegIdxWidth     = 6,
    parameter int OperandsPerInst = 2,
    parameter int NumCollectors   = 4,
    localparam int TagWidth       = $clog2(NumTags),
    localparam int WidWidth       = $clog2(NumWarps),
    localparam int IidWidth       = TagWidth + WidWidth,
    localparam int DataWidth      = WarpWidth * RegWidth
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    output logic                                        opc_ready_o,
    input  logic                                        disp_valid_i,
    input  logic [IidWidth-1:0]                         disp_tag_i,
    input  logic [RegIdxWidth-1:0]                      disp_dst_i,
    input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0] disp_operands_i,
    output logic                                        rf_req_valid_o,
    input  logic                                        rf_req_ready_i,
    output logic [WidWidth-1:0]                         rf_req_wid_o,
    output logic [RegIdxWidth-1:0]                      rf_req_reg_o,
    input  logic [DataWidth-1:0]                        rf_rsp_data_i,
    output logic                                        eu_valid_o,
    input  logic                                        eu_ready_i,
    output logic [IidWidth-1:0]                         eu_tag_o,
    output logic [RegIdxWidth-1:0]                      eu_dst_o,
    output logic [OperandsPerInst-1:0][DataWidth-1:0]   eu_operands_o
);

    localparam int SlotIdxWidth = (NumCollectors > 1) ? $clog2(NumCollectors) : 1;
    localparam int OpIdxWidth   = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1;

    logic [NumCollectors-1:0] slot_free, slot_ready, slot_wants;
    logic [NumCollectors-1:0] alloc, req_fire, capture, retire;
    logic [OpIdxWidth-1:0]    slot_req_op  [NumCollectors];
    logic [RegIdxWidth-1:0]   slot_req_reg [NumCollectors];
    logic [IidWidth-1:0]      slot_tag     [NumCollectors];
    logic [RegIdxWidth-1:0]   slot_dst     [NumCollectors];
    logic [OperandsPerInst-1:0][DataWidth-1:0] slot_data [NumCollectors];

    logic [SlotIdxWidth-1:0] rf_idx, eu_idx, pend_slot;
    logic [OpIdxWidth-1:0]   pend_op;
    logic                    pend_valid, alloc_found;

    assign opc_ready_o = |slot_free;

    always_comb begin
        alloc       = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NumCollectors; i++) begin
            if (!alloc_found && slot_free[i]) begin
                alloc[i]    = disp_valid_i;
                alloc_found = 1'b1;
            end
        end
    end

    always_comb begin
        capture = '0;
        for (int i = 0; i < NumCollectors; i++)
            capture[i] = pend_valid && (pend_slot == SlotIdxWidth'(i));
    end

    for (genvar i = 0; i < NumCollectors; i++) begin : g_slot
        collector_slot #(
            .IidWidth(IidWidth), .RegIdxWidth(RegIdxWidth), .OperandsPerInst(OperandsPerInst),
            .DataWidth(DataWidth), .OpIdxWidth(OpIdxWidth)
        ) u_slot (
            .clk(clk_i), .rst_n(rst_ni),
            .alloc(alloc[i]), .alloc_tag(disp_tag_i), .alloc_dst(disp_dst_i),
            .alloc_ops(disp_operands_i),
            .req_fire(req_fire[i]), .wants(slot_wants[i]),
            .req_op(slot_req_op[i]), .req_reg(slot_req_reg[i]),
            .capture(capture[i]), .capture_op(pend_op), .capture_data(rf_rsp_data_i),
            .retire(retire[i]), .free(slot_free[i]), .ready(slot_ready[i]),
            .tag(slot_tag[i]), .dst(slot_dst[i]), .data(slot_data[i])
        );
    end

    rr_arb_tree #(.NumIn(NumCollectors), .IdxWidth(SlotIdxWidth)) u_rf_arb (
        .clk(clk_i), .rst_n(rst_ni), .reqs(slot_wants), .grants(req_fire),
        .valid(rf_req_valid_o), .ready(rf_req_ready_i), .idx(rf_idx)
    );

    assign rf_req_wid_o = slot_tag[rf_idx][TagWidth +: WidWidth];
    assign rf_req_reg_o = slot_req_reg[rf_idx];

    // Response returns one cycle after the handshake; remember where it belongs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid <= 1'b0;
            pend_slot  <= '0;
            pend_op    <= '0;
        end else begin
            pend_valid <= rf_req_valid_o && rf_req_ready_i;
            if (rf_req_valid_o && rf_req_ready_i) begin
                pend_slot <= rf_idx;
                pend_op   <= slot_req_op[rf_idx];
            end
        end
    end

    rr_arb_tree #(.NumIn(NumCollectors), .IdxWidth(SlotIdxWidth)) u_eu_arb (
        .clk(clk_i), .rst_n(rst_ni), .reqs(slot_ready), .grants(retire),
        .valid(eu_valid_o), .ready(eu_ready_i), .idx(eu_idx)
    );

    assign eu_tag_o      = slot_tag[eu_idx];
    assign eu_dst_o      = slot_dst[eu_idx];
    assign eu_operands_o = slot_data[eu_idx];

endmodule

// File: tb/tb_operand_collector.sv
// tb/tb_operand_collector.sv - scoreboard bench for operand_collector
module tb_operand_collector;

    typedef struct {
        logic [5:0]    tag;
        logic [5:0]    dst;
        logic [1023:0] d0;
        logic [1023:0] d1;
    } exp_t;

    logic                  clk, rst_ni;
    logic                  opc_ready_o, disp_valid_i;
    logic [5:0]            disp_tag_i, disp_dst_i;
    logic [1:0][5:0]       disp_operands_i;
    logic                  rf_req_valid_o, rf_req_ready_i;
    logic [2:0]            rf_req_wid_o;
    logic [5:0]            rf_req_reg_o;
    logic [1023:0]         rf_rsp_data_i;
    logic                  eu_valid_o, eu_ready_i;
    logic [5:0]            eu_tag_o, eu_dst_o;
    logic [1:0][1023:0]    eu_operands_o;

    exp_t       exp_q[$];
    logic [8:0] rf_log[$];
    logic [5:0] eu_log[$];
    int         eu_cyc[$];
    int         n_tests, n_fail, cyc, mon_k;
    logic [2:0] rsp_wid;
    logic [5:0] rsp_reg;

    operand_collector dut (
        .clk_i(clk), .rst_ni(rst_ni), .opc_ready_o(opc_ready_o),
        .disp_valid_i(disp_valid_i), .disp_tag_i(disp_tag_i), .disp_dst_i(disp_dst_i),
        .disp_operands_i(disp_operands_i),
        .rf_req_valid_o(rf_req_valid_o), .rf_req_ready_i(rf_req_ready_i),
        .rf_req_wid_o(rf_req_wid_o), .rf_req_reg_o(rf_req_reg_o), .rf_rsp_data_i(rf_rsp_data_i),
        .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_tag_o(eu_tag_o),
        .eu_dst_o(eu_dst_o), .eu_operands_o(eu_operands_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1023:0] rf_val(input logic [2:0] wid, input logic [5:0] r);
        logic [31:0] w;
        if (r == 6'd3) return {128{8'hAA}};
        if (r == 6'd5) return {128{8'h55}};
        w = {8'hD0, 5'b0, wid, 2'b0, r, 8'h5A};
        return {32{w}};
    endfunction

    // Register-file model: answers the request accepted on the previous edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_req_valid_o && rf_req_ready_i) begin
            rsp_wid <= rf_req_wid_o;
            rsp_reg <= rf_req_reg_o;
        end
    end
    assign rf_rsp_data_i = rf_val(rsp_wid, rsp_reg);

    always @(negedge clk) begin
        if (rst_ni && eu_valid_o && eu_ready_i) begin
            mon_k = -1;
            foreach (exp_q[j]) if (mon_k < 0 && exp_q[j].tag == eu_tag_o) mon_k = j;
            n_tests++;
            if (mon_k < 0) begin
                n_fail++;
                $display("FAIL eu_unexpected: tag %h was not expected", eu_tag_o);
            end else begin
                if (eu_dst_o !== exp_q[mon_k].dst || eu_operands_o[0] !== exp_q[mon_k].d0 ||
                    eu_operands_o[1] !== exp_q[mon_k].d1) begin
                    n_fail++;
                    $display("FAIL eu_data tag %h: dst %h want %h, op0[31:0] %h want %h, op1[31:0] %h want %h",
                             eu_tag_o, eu_dst_o, exp_q[mon_k].dst, eu_operands_o[0][31:0],
                             exp_q[mon_k].d0[31:0], eu_operands_o[1][31:0], exp_q[mon_k].d1[31:0]);
                end
                exp_q.delete(mon_k);
            end
            eu_log.push_back(eu_tag_o);
            eu_cyc.push_back(cyc);
        end
        if (rst_ni && rf_req_valid_o && rf_req_ready_i)
            rf_log.push_back({rf_req_wid_o, rf_req_reg_o});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic dispatch(input logic [5:0] tag, input logic [5:0] dst, input logic [5:0] op0,
                            input logic [5:0] op1, input logic [1023:0] d0, input logic [1023:0] d1);
        int n;
        n = 0;
        disp_valid_i    = 1'b1;
        disp_tag_i      = tag;
        disp_dst_i      = dst;
        disp_operands_i = {op1, op0};
        while (!opc_ready_o && n < 50) begin
            tick();
            n++;
        end
        check("dispatch_accept", opc_ready_o, 1);
        if (opc_ready_o) exp_q.push_back('{tag, dst, d0, d1});
        tick();
        disp_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic single(input string nm);
        int lat, s;
        s = rf_log.size();
        eu_ready_i = 1'b1;
        rf_req_ready_i = 1'b1;
        dispatch(6'h0A, 6'd17, 6'd3, 6'd5, {128{8'hAA}}, {128{8'h55}});
        lat = 0;
        while (!eu_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        check({nm, "_latency"}, lat, 4);
        check({nm, "_tag"}, eu_tag_o, 6'h0A);
        check({nm, "_dst"}, eu_dst_o, 6'd17);
        drain(20);
        check({nm, "_nreq"}, rf_log.size() - s, 2);
        if (rf_log.size() >= s + 2) begin
            check({nm, "_req0"}, rf_log[s], {3'd1, 6'd3});
            check({nm, "_req1"}, rf_log[s+1], {3'd1, 6'd5});
        end
    endtask

    initial begin
        logic [5:0]         cap_tag;
        logic [1:0][1023:0] cap_d;
        int s, n, bad;
        n_tests = 0; n_fail = 0; cyc = 0;
        rst_ni = 1'b0; disp_valid_i = 1'b0; disp_tag_i = '0; disp_dst_i = '0;
        disp_operands_i = '0; rf_req_ready_i = 1'b1; eu_ready_i = 1'b0;
        rsp_wid = '0; rsp_reg = '0;
        repeat (3) tick();
        check("rst_opc_ready", opc_ready_o, 1);
        check("rst_rf_valid", rf_req_valid_o, 0);
        check("rst_eu_valid", eu_valid_o, 0);
        rst_ni = 1'b1;
        tick();

        single("t1");

        // Fill all four slots, then show the fifth waits for a release
        eu_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            disp_valid_i    = 1'b1;
            disp_tag_i      = 6'h10 + 6'(i);
            disp_dst_i      = 6'(i);
            disp_operands_i = {6'(i + 16), 6'(i + 8)};
            if (i < 4) begin
                check("t2_accept", opc_ready_o, 1);
                if (opc_ready_o)
                    exp_q.push_back('{disp_tag_i, disp_dst_i, rf_val(3'd2, 6'(i + 8)), rf_val(3'd2, 6'(i + 16))});
                tick();
            end else begin
                check("t2_full", opc_ready_o, 0);
            end
        end
        n = 0;
        while (!eu_valid_o && n < 30) begin
            tick();
            n++;
        end
        check("t2_eu_valid", eu_valid_o, 1);
        check("t2_still_full", opc_ready_o, 0);
        eu_ready_i = 1'b1;
        tick();
        eu_ready_i = 1'b0;
        check("t2_reopen", opc_ready_o, 1);
        if (opc_ready_o) exp_q.push_back('{6'h14, 6'd4, rf_val(3'd2, 6'd12), rf_val(3'd2, 6'd20)});
        tick();
        disp_valid_i = 1'b0;
        eu_ready_i = 1'b1;
        drain(60);

        // Register-file stall holds the request steady
        rf_req_ready_i = 1'b0;
        s = rf_log.size();
        dispatch(6'h21, 6'd2, 6'd9, 6'd12, rf_val(3'd4, 6'd9), rf_val(3'd4, 6'd12));
        n = 0;
        while (!rf_req_valid_o && n < 10) begin
            tick();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            check("t3_stall_valid", rf_req_valid_o, 1);
            check("t3_stall_wid", rf_req_wid_o, 3'd4);
            check("t3_stall_reg", rf_req_reg_o, 6'd9);
            if (k < 2) tick();
        end
        rf_req_ready_i = 1'b1;
        drain(30);
        check("t3_nreq", rf_log.size() - s, 2);
        if (rf_log.size() >= s + 2) begin
            check("t3_req0", rf_log[s], {3'd4, 6'd9});
            check("t3_req1", rf_log[s+1], {3'd4, 6'd12});
        end

        // Two READY slots: stall, then round-robin release
        eu_ready_i = 1'b0;
        dispatch(6'h30, 6'd1, 6'd1, 6'd2, rf_val(3'd6, 6'd1), rf_val(3'd6, 6'd2));
        dispatch(6'h31, 6'd2, 6'd2, 6'd4, rf_val(3'd6, 6'd2), rf_val(3'd6, 6'd4));
        repeat (12) tick();
        check("t4_eu_valid", eu_valid_o, 1);
        cap_tag = eu_tag_o;
        cap_d   = eu_operands_o;
        tick();
        tick();
        check("t4_tag_stable", eu_tag_o, cap_tag);
        check("t4_data_stable", eu_operands_o == cap_d, 1);
        s = eu_log.size();
        eu_ready_i = 1'b1;
        drain(10);
        check("t4_ngrant", eu_log.size() - s, 2);
        if (eu_log.size() >= s + 2) begin
            check("t4_first", eu_log[s], cap_tag);
            check("t4_alternate", eu_log[s] ^ eu_log[s+1], 1);
            check("t4_back_to_back", eu_cyc[s+1] - eu_cyc[s], 1);
        end

        // Reset while three slots collect and a read is outstanding
        dispatch(6'h00, 6'd7, 6'd8, 6'd9, '0, '0);
        dispatch(6'h01, 6'd7, 6'd10, 6'd11, '0, '0);
        dispatch(6'h02, 6'd7, 6'd12, 6'd13, '0, '0);
        n = 0;
        while (!(rf_req_valid_o && rf_req_ready_i) && n < 20) begin
            tick();
            n++;
        end
        check("t5_pending", rf_req_valid_o, 1);
        tick();
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        check("t5_rst_opc_ready", opc_ready_o, 1);
        check("t5_rst_eu_valid", eu_valid_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("t5_post_opc_ready", opc_ready_o, 1);
        check("t5_post_rf_valid", rf_req_valid_o, 0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (eu_valid_o || !opc_ready_o) bad++;
            tick();
        end
        check("t5_quiet", bad, 0);
        single("t5");

        drain(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_collector.md
# operand_collector

Receiving end of the dispatch interface in the compute unit. Buffers up to `NumCollectors` dispatched instructions and reads their source registers from the register file through a single read port. Once every operand of an instruction has arrived, it presents the instruction plus operand data to the execution units, keeping the dispatcher's instruction ID (iid) unchanged so that completion can be reported back.

## Interface
Parameters:
- `NumTags`, 8: inflight tags per warp; `TagWidth = $clog2(NumTags)`
- `NumWarps`, 8: warps per compute unit; `WidWidth = $clog2(NumWarps)`
- `WarpWidth`, 32: threads per warp
- `RegWidth`, 32: bits per thread register
- `RegIdxWidth`, 6: register index width
- `OperandsPerInst`, 2: source operands per instruction
- `NumCollectors`, 4: instruction slots
- Derived, do not override: `iid_t = logic [TagWidth+WidWidth-1:0]`, `reg_idx_t`, `data_t = logic [WarpWidth*RegWidth-1:0]`

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`, in, 1: clock
- `rst_ni`, in, 1: async active-low reset
- `opc_ready_o`, out, 1: a free slot exists
- `disp_valid_i`, in, 1: dispatch valid
- `disp_tag_i`, in, iid_t: {warp id, tag}
- `disp_dst_i`, in, reg_idx_t: destination register
- `disp_operands_i`, in, reg_idx_t[OperandsPerInst]: source registers
- `rf_req_valid_o`, out, 1: register read request
- `rf_req_ready_i`, in, 1: register file accepts the request
- `rf_req_wid_o`, out, WidWidth: warp of the read
- `rf_req_reg_o`, out, reg_idx_t: register to read
- `rf_rsp_data_i`, in, data_t: read data, valid exactly one cycle after the request handshake
- `eu_valid_o`, out, 1: instruction ready for execution
- `eu_ready_i`, in, 1: execution unit accepts
- `eu_tag_o`, out, iid_t: iid, passed through unchanged
- `eu_dst_o`, out, reg_idx_t: destination register
- `eu_operands_o`, out, data_t[OperandsPerInst]: operand data

## Operation
- Each slot is in one of three states: FREE, COLLECT or READY. It also holds the iid, dst, operand indices, a per-operand `requested` bit, a per-operand `valid` bit and the operand data.
- FREE→COLLECT: on a dispatch handshake (`disp_valid_i && opc_ready_o`), the lowest-index FREE slot is written. All `requested` and `valid` bits are cleared.
- RF read arbitration:
  - Fair round-robin among COLLECT slots that still have an unrequested operand.
  - The winning slot requests its lowest-index unrequested operand; `rf_req_wid_o` = iid[TagWidth+:WidWidth].
  - On the request handshake, that operand's `requested` bit is set, and the slot/operand pair is registered as pending.
  - The next cycle, `rf_rsp_data_i` is stored into the pending slot/operand and its `valid` bit is set.
- COLLECT→READY: in the cycle after the last operand's data is captured.
- Output arbitration: fair round-robin among READY slots drives the `eu_*` outputs. On the `eu_valid_o && eu_ready_i` handshake the slot goes READY→FREE.
- No ordering is guaranteed between slots. The dispatcher has already resolved dependencies.
- `opc_ready_o` is a function of registered slot state only. It does not depend on `disp_valid_i` or `eu_ready_i`.

## Timing
- Reset values: all slots FREE, no read pending, `opc_ready_o`=1, `rf_req_valid_o`=0, `eu_valid_o`=0. The data outputs are don't-care while their valid is low.
- Reset asserted mid-operation discards every slot and the pending read. A response arriving after reset is ignored.
- Minimum latency, dispatch handshake to `eu_valid_o`: OperandsPerInst+2 cycles (4 by default, with `rf_req_ready_i`=1).
- At most one read request per cycle. A new slot can request no earlier than the cycle after its allocation.
- A slot freed by an EU handshake is reusable from the next cycle, not the same cycle.
- Full: with all slots non-FREE, `opc_ready_o`=0, and `disp_valid_i` is ignored.
- `rf_req_valid_o` held while `rf_req_ready_i`=0: the request stays stable and arbitration does not advance.
- `eu_valid_o` held while `eu_ready_i`=0: the same slot and data are held stable (no lock-in violation).
- Dispatch allocation, RF capture and EU release all in one cycle, on different slots, are all honoured.

## Structure
- `iid_t` layout ({wid, tag}) and the slot state enum belong in the shared compute-unit package. The dispatcher and the execution units use the same iid layout.
- Both arbiters reuse the existing `rr_arb_tree`, configured fair, no external priority and no lock-in.
- A per-slot sub-module `collector_slot` (state, operand bookkeeping and data storage) is natural. The top level keeps allocation, the two arbiters and the pending-read register.

## Test plan
- Single dispatch of iid 0x0A, ops {r3, r5}, with RF returning 0xAA.. then 0x55..: requests r3, then r5 with wid 1. `eu_valid_o` is raised 4 cycles after the handshake, with operands {0xAA.., 0x55..}, tag 0x0A and dst passed through.
- 5 back-to-back dispatches with `eu_ready_i`=0: the first 4 are accepted and `opc_ready_o` falls. One EU handshake brings `opc_ready_o` back the following cycle, and the 5th is accepted.
- `rf_req_ready_i` low for 3 cycles: the request is held stable. After the stall, data is captured into the correct slot/operand with no loss or duplication.
- Two READY slots with `eu_ready_i`=1: the EU grants alternate slot 0 and slot 1. An `eu_ready_i`=0 stall keeps the selected tag and data stable.
- Reset asserted while 3 slots are collecting and a read is pending: after release `opc_ready_o`=1 and `eu_valid_o`=0, and no stale response is written.
